// File: rtl/debug_responder.sv
// Debug command responder: collects a command plus data/address arguments
// and executes it against the halt control, register file and memory ports.
module debug_responder #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_debug_command,
    input  logic              send_debug_command_data_argument,
    input  logic              send_debug_command_address_argument,
    input  logic [XLEN-1:0]   debug_bus,
    output logic              core_busy,
    output logic [XLEN-1:0]   debug_result,
    output logic              debug_error,
    output logic              core_halt,
    input  logic              instr_retired,
    output logic [4:0]        dbg_reg_addr,
    output logic              dbg_reg_we,
    output logic [XLEN-1:0]   dbg_reg_wdata,
    input  logic [XLEN-1:0]   dbg_reg_rdata,
    output logic [ADDR_W-1:0] dbg_mem_addr,
    output logic              dbg_mem_re,
    output logic              dbg_mem_we,
    output logic [XLEN-1:0]   dbg_mem_wdata,
    input  logic [XLEN-1:0]   dbg_mem_rdata,
    input  logic              dbg_mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_DATA,
        S_GET_ADDR,
        S_EXEC,
        S_MEM_WAIT,
        S_STEP_WAIT
    } state_t;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_HALT      = 4'd1;
    localparam logic [3:0] OP_RESUME    = 4'd2;
    localparam logic [3:0] OP_READ_REG  = 4'd3;
    localparam logic [3:0] OP_WRITE_REG = 4'd4;
    localparam logic [3:0] OP_READ_MEM  = 4'd5;
    localparam logic [3:0] OP_WRITE_MEM = 4'd6;
    localparam logic [3:0] OP_STEP      = 4'd7;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_op;
    logic [XLEN-1:0]   r_data;
    logic [ADDR_W-1:0] r_addr;

    logic              w_done;
    logic [XLEN-1:0]   w_result;
    logic              w_error;
    logic              w_halt;
    logic              w_priv;
    logic              w_illegal;
    logic              w_is_read;

    assign w_priv    = (r_op >= OP_READ_REG) && (r_op <= OP_STEP);
    assign w_illegal = (r_op > OP_STEP);
    assign w_is_read = (r_op == OP_READ_MEM);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_data       <= '0;
            r_addr       <= '0;
            core_busy    <= 1'b0;
            debug_result <= '0;
            debug_error  <= 1'b0;
            core_halt    <= 1'b0;
        end else begin
            r_state   <= w_next;
            core_halt <= w_halt;
            if (r_state == S_IDLE && send_debug_command) begin
                r_op      <= debug_bus[3:0];
                core_busy <= 1'b1;
            end
            if (r_state == S_GET_DATA && send_debug_command_data_argument)
                r_data <= debug_bus;
            if (r_state == S_GET_ADDR && send_debug_command_address_argument)
                r_addr <= ADDR_W'(debug_bus);
            if (w_done) begin
                core_busy    <= 1'b0;
                debug_result <= w_result;
                debug_error  <= w_error;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_done        = 1'b0;
        w_result      = debug_result;
        w_error       = 1'b0;
        w_halt        = core_halt;
        dbg_reg_addr  = '0;
        dbg_reg_we    = 1'b0;
        dbg_reg_wdata = '0;
        dbg_mem_addr  = '0;
        dbg_mem_re    = 1'b0;
        dbg_mem_we    = 1'b0;
        dbg_mem_wdata = '0;

        unique case (r_state)
            S_IDLE: begin
                if (send_debug_command)
                    w_next = S_GET_DATA;
            end
            S_GET_DATA: begin
                if (send_debug_command_data_argument)
                    w_next = S_GET_ADDR;
            end
            S_GET_ADDR: begin
                if (send_debug_command_address_argument)
                    w_next = S_EXEC;
            end
            S_EXEC: begin
                // privileged commands need a halted core; no port is touched otherwise
                if (w_illegal || (w_priv && !core_halt)) begin
                    w_done   = 1'b1;
                    w_result = '1;
                    w_error  = 1'b1;
                end else begin
                    case (r_op)
                        OP_NOP: begin
                            w_done   = 1'b1;
                            w_result = '0;
                        end
                        OP_HALT: begin
                            w_done   = 1'b1;
                            w_halt   = 1'b1;
                            w_result = XLEN'(1);
                        end
                        OP_RESUME: begin
                            w_done   = 1'b1;
                            w_halt   = 1'b0;
                            w_result = XLEN'(1);
                        end
                        OP_READ_REG: begin
                            w_done       = 1'b1;
                            dbg_reg_addr = r_addr[4:0];
                            w_result     = dbg_reg_rdata;
                        end
                        OP_WRITE_REG: begin
                            w_done       = 1'b1;
                            dbg_reg_addr = r_addr[4:0];
                            if (r_addr[4:0] != 5'd0) begin
                                dbg_reg_we    = 1'b1;
                                dbg_reg_wdata = r_data;
                                w_result      = r_data;
                            end else begin
                                w_result = '0;
                            end
                        end
                        OP_READ_MEM, OP_WRITE_MEM: begin
                            dbg_mem_addr  = r_addr;
                            dbg_mem_re    = w_is_read;
                            dbg_mem_we    = !w_is_read;
                            dbg_mem_wdata = w_is_read ? '0 : r_data;
                            w_next        = S_MEM_WAIT;
                        end
                        OP_STEP: begin
                            w_halt = 1'b0;
                            w_next = S_STEP_WAIT;
                        end
                        default: begin
                            w_done   = 1'b1;
                            w_result = '1;
                            w_error  = 1'b1;
                        end
                    endcase
                end
            end
            S_MEM_WAIT: begin
                dbg_mem_addr  = r_addr;
                dbg_mem_re    = w_is_read;
                dbg_mem_we    = !w_is_read;
                dbg_mem_wdata = w_is_read ? '0 : r_data;
                if (dbg_mem_ready) begin
                    w_done   = 1'b1;
                    w_result = w_is_read ? dbg_mem_rdata : r_data;
                end
            end
            S_STEP_WAIT: begin
                if (instr_retired) begin
                    w_done   = 1'b1;
                    w_halt   = 1'b1;
                    w_result = XLEN'(1);
                end
            end
            default: w_next = S_IDLE;
        endcase

        if (w_done)
            w_next = S_IDLE;
    end

endmodule

// File: tb/tb_debug_responder.sv
// Directed self-checking bench for debug_responder with a small
// register-file model and a hand-driven memory responder.
module tb_debug_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_s;
    logic        data_s;
    logic        addr_s;
    logic [31:0] bus;
    logic        busy;
    logic [31:0] result;
    logic        err;
    logic        halt;
    logic        retired;
    logic [4:0]  reg_addr;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic [31:0] rf [32];
    int n_assert = 0;
    int n_fail   = 0;
    int cnt;

    always #5 clk = ~clk;

    assign reg_rdata = rf[reg_addr];
    always @(posedge clk)
        if (reg_we) rf[reg_addr] <= reg_wdata;

    debug_responder #(.XLEN(32), .ADDR_W(32)) dut (
        .clk                                 (clk),
        .rst                                 (rst),
        .send_debug_command                  (cmd_s),
        .send_debug_command_data_argument    (data_s),
        .send_debug_command_address_argument (addr_s),
        .debug_bus                           (bus),
        .core_busy                           (busy),
        .debug_result                        (result),
        .debug_error                         (err),
        .core_halt                           (halt),
        .instr_retired                       (retired),
        .dbg_reg_addr                        (reg_addr),
        .dbg_reg_we                          (reg_we),
        .dbg_reg_wdata                       (reg_wdata),
        .dbg_reg_rdata                       (reg_rdata),
        .dbg_mem_addr                        (mem_addr),
        .dbg_mem_re                          (mem_re),
        .dbg_mem_we                          (mem_we),
        .dbg_mem_wdata                       (mem_wdata),
        .dbg_mem_rdata                       (mem_rdata),
        .dbg_mem_ready                       (mem_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // leaves the bench in the EXEC cycle
    task automatic issue(input logic [3:0] op, input logic [31:0] d,
                         input logic [31:0] a, input bit stray);
        cmd_s = 1'b1;
        bus   = {28'h0, op};
        tick();
        cmd_s = 1'b0;
        chk("busy_after_cmd", {31'b0, busy}, 32'd1);
        if (stray) begin
            addr_s = 1'b1;
            cmd_s  = 1'b1;
            bus    = 32'hFFFF_FFF0;
            tick();
            addr_s = 1'b0;
            cmd_s  = 1'b0;
        end
        data_s = 1'b1;
        bus    = d;
        tick();
        data_s = 1'b0;
        addr_s = 1'b1;
        bus    = a;
        tick();
        addr_s = 1'b0;
        bus    = '0;
        chk("busy_in_exec", {31'b0, busy}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst = 1'b0; cmd_s = 0; data_s = 0; addr_s = 0; bus = '0;
        retired = 0; mem_rdata = '0; mem_ready = 0;
        tick();
        tick();
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_halt", {31'b0, halt}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_result", result, 0);
        chk("rst_mem_re", {31'b0, mem_re}, 0);
        rst = 1'b1;
        tick();

        // NOP, not halted
        issue(4'd0, 32'h0, 32'h0, 0);
        tick();
        chk("nop_busy", {31'b0, busy}, 0);
        chk("nop_result", result, 0);

        // READ_REG while running is an error with no port access
        issue(4'd3, 32'h0, 32'h5, 0);
        chk("rr_run_addr", {27'b0, reg_addr}, 0);
        tick();
        chk("rr_run_result", result, 32'hFFFF_FFFF);
        chk("rr_run_err", {31'b0, err}, 1);
        issue(4'd0, 32'h0, 32'h0, 0);
        tick();
        chk("nop_clr_err", {31'b0, err}, 0);
        chk("nop_clr_result", result, 0);

        // READ_MEM while running: no request
        issue(4'd5, 32'h0, 32'h100, 0);
        chk("rm_run_re", {31'b0, mem_re}, 0);
        tick();
        chk("rm_run_result", result, 32'hFFFF_FFFF);
        chk("rm_run_err", {31'b0, err}, 1);

        // illegal opcode
        issue(4'd9, 32'h0, 32'h0, 0);
        tick();
        chk("ill_result", result, 32'hFFFF_FFFF);
        chk("ill_err", {31'b0, err}, 1);

        // HALT with stray strobes in GET_DATA
        issue(4'd1, 32'h0, 32'h0, 1);
        chk("halt_not_yet", {31'b0, halt}, 0);
        tick();
        chk("halt_halt", {31'b0, halt}, 1);
        chk("halt_busy", {31'b0, busy}, 0);
        chk("halt_result", result, 1);
        chk("halt_err", {31'b0, err}, 0);

        // WRITE_REG x5
        issue(4'd4, 32'h1234_5678, 32'h5, 0);
        chk("wr_we_exec", {31'b0, reg_we}, 1);
        chk("wr_addr", {27'b0, reg_addr}, 5);
        chk("wr_wdata", reg_wdata, 32'h1234_5678);
        tick();
        chk("wr_we_after", {31'b0, reg_we}, 0);
        chk("wr_result", result, 32'h1234_5678);
        chk("wr_busy", {31'b0, busy}, 0);
        chk("wr_model", rf[5], 32'h1234_5678);

        // READ_REG x5
        issue(4'd3, 32'h0, 32'h5, 0);
        tick();
        chk("rr_result", result, 32'h1234_5678);
        chk("rr_err", {31'b0, err}, 0);

        // WRITE_REG x0 is suppressed
        issue(4'd4, 32'hDEAD_BEEF, 32'h0, 0);
        chk("wr0_we", {31'b0, reg_we}, 0);
        tick();
        chk("wr0_result", result, 0);
        chk("wr0_model", rf[0], 0);

        // READ_MEM 0x100, ready on the fourth request cycle
        issue(4'd5, 32'h0, 32'h100, 0);
        chk("rm_addr", mem_addr, 32'h100);
        cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            if (mem_re) cnt++;
            chk("rm_busy_hold", {31'b0, busy}, 1);
            if (i == 4) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hCAFE_F00D;
            end
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = '0;
        chk("rm_re_cycles", cnt, 4);
        chk("rm_re_drop", {31'b0, mem_re}, 0);
        chk("rm_busy_done", {31'b0, busy}, 0);
        chk("rm_result", result, 32'hCAFE_F00D);

        // WRITE_MEM 0x200, ready in first wait cycle
        issue(4'd6, 32'h0000_A5A5, 32'h200, 0);
        chk("wm_we", {31'b0, mem_we}, 1);
        chk("wm_wdata", mem_wdata, 32'h0000_A5A5);
        chk("wm_addr", mem_addr, 32'h200);
        tick();
        chk("wm_we_hold", {31'b0, mem_we}, 1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("wm_we_drop", {31'b0, mem_we}, 0);
        chk("wm_result", result, 32'h0000_A5A5);
        chk("wm_busy", {31'b0, busy}, 0);

        // STEP: released for five cycles, then re-halted
        issue(4'd7, 32'h0, 32'h0, 0);
        tick();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (!halt) cnt++;
            chk("step_busy", {31'b0, busy}, 1);
            if (i == 4) retired = 1'b1;
            tick();
        end
        retired = 1'b0;
        chk("step_run_cycles", cnt, 5);
        chk("step_halt", {31'b0, halt}, 1);
        chk("step_busy_done", {31'b0, busy}, 0);
        chk("step_result", result, 1);

        // reset during MEM_WAIT
        issue(4'd5, 32'h0, 32'h300, 0);
        tick();
        chk("rst_mw_re", {31'b0, mem_re}, 1);
        rst = 1'b0;
        tick();
        chk("rst_mw_re_drop", {31'b0, mem_re}, 0);
        chk("rst_mw_busy", {31'b0, busy}, 0);
        chk("rst_mw_halt", {31'b0, halt}, 0);
        chk("rst_mw_result", result, 0);
        rst = 1'b1;
        issue(4'd0, 32'h0, 32'h0, 0);
        tick();
        chk("post_rst_nop_busy", {31'b0, busy}, 0);
        chk("post_rst_nop_err", {31'b0, err}, 0);

        // HALT then RESUME
        issue(4'd1, 32'h0, 32'h0, 0);
        tick();
        issue(4'd2, 32'h0, 32'h0, 0);
        tick();
        chk("resume_halt", {31'b0, halt}, 0);
        chk("resume_result", result, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_responder.md
DEBUG_RESPONDER -- requirements
Module: debug_responder

Interface
REQ-001 Parameter: XLEN, default 32, width of debug bus, data and result.
REQ-002 Parameter: ADDR_W, default 32, width of the debug memory address.
REQ-003 Ports, in order:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-low reset; one clock domain, reset sampled on the rising edge of clk only.
- send_debug_command  in  1  strobe: debug_bus holds the command.
- send_debug_command_data_argument  in  1  strobe: debug_bus holds the data argument.
- send_debug_command_address_argument  in  1  strobe: debug_bus holds the address argument.
- debug_bus  in  XLEN  shared command/argument bus.
- core_busy  out  1  high while a command is being accepted or executed.
- debug_result  out  XLEN  result of the last command; valid whenever core_busy=0.
- debug_error  out  1  last command failed.
- core_halt  out  1  stalls the core pipeline.
- instr_retired  in  1  core retired one instruction this cycle.
- dbg_reg_addr  out  5  register-file index.
- dbg_reg_we  out  1  register-file write enable.
- dbg_reg_wdata  out  XLEN  register-file write data.
- dbg_reg_rdata  in  XLEN  register-file read data, combinational from dbg_reg_addr.
- dbg_mem_addr  out  ADDR_W  memory address.
- dbg_mem_re / dbg_mem_we  out  1  memory read / write request, held until dbg_mem_ready.
- dbg_mem_wdata  out  XLEN  memory write data.
- dbg_mem_rdata  in  XLEN  memory read data, valid with dbg_mem_ready.
- dbg_mem_ready  in  1  memory completes the request.

Function
REQ-004 Command opcode is debug_bus[3:0]:
- 0 NOP, 1 HALT, 2 RESUME, 3 READ_REG, 4 WRITE_REG, 5 READ_MEM, 6 WRITE_MEM, 7 STEP.
- Other values are illegal.
REQ-005 FSM states: IDLE, GET_DATA, GET_ADDR, EXEC, MEM_WAIT, STEP_WAIT.
REQ-006 IDLE: send_debug_command=1 -> latch the opcode, set core_busy on that edge, go to GET_DATA.
REQ-007 GET_DATA: wait for send_debug_command_data_argument; latch debug_bus as the data argument; go to GET_ADDR.
REQ-008 GET_ADDR: wait for send_debug_command_address_argument; latch debug_bus as the address argument; go to EXEC.
REQ-009 Strobes that do not match the current state are ignored and do not change state.
REQ-010 EXEC (one cycle) actions by opcode:
- NOP: result 0.
- HALT: core_halt<=1, result 1.
- RESUME: core_halt<=0, result 1.
- READ_REG: result dbg_reg_rdata, with dbg_reg_addr = address[4:0].
- WRITE_REG: dbg_reg_we=1 for exactly this cycle, result = data.
- READ_MEM / WRITE_MEM: assert the request, go to MEM_WAIT.
- STEP: core_halt<=0, go to STEP_WAIT.
REQ-011 Writes to register index 0 are suppressed (dbg_reg_we stays 0) and return result 0.
REQ-012 MEM_WAIT: hold re/we, address and wdata stable; on dbg_mem_ready, drop the request that cycle. Result is dbg_mem_rdata for reads and data for writes.
REQ-013 STEP_WAIT: on the first instr_retired, core_halt<=1, result 1.
REQ-014 Command completion, on one and the same edge:
- debug_result and debug_error are updated;
- core_busy<=0;
- FSM returns to IDLE.
REQ-015 Latency from the address strobe edge to core_busy=0:
- 1 cycle for NOP, HALT, RESUME, READ_REG, WRITE_REG;
- 1 + memory wait cycles for memory commands;
- 1 + retire wait cycles for STEP.
REQ-016 core_busy is 1 from the cycle after the command strobe. No combinational path runs from the strobes to core_busy.
REQ-017 Any of READ_REG, WRITE_REG, READ_MEM, WRITE_MEM or STEP issued while core_halt=0 is an error:
- no port access is made;
- result = all ones, debug_error=1.
REQ-018 An illegal opcode gives result = all ones and debug_error=1. Every successful command clears debug_error.
REQ-019 debug_result holds its value between commands. It is never updated while core_busy=0.
REQ-020 dbg_reg_we, dbg_mem_re and dbg_mem_we are 0 in every state not named in REQ-010 and REQ-012.

Reset
REQ-021 When rst=0 at a rising edge, the following are cleared:
- FSM to IDLE;
- core_busy, debug_error, core_halt, dbg_reg_we, dbg_mem_re and dbg_mem_we to 0;
- debug_result and latched arguments to 0.
REQ-022 Reset during any state, including MEM_WAIT and STEP_WAIT, abandons the command and drops the memory request on the same edge.

Verification
REQ-023 HALT sequence (cmd=1, data=0, addr=0, one strobe per cycle):
- core_halt=1 and core_busy=0 one cycle after the address strobe;
- debug_result=1.
REQ-024 Halted, WRITE_REG (data=0x1234_5678, addr=5), then READ_REG (addr=5) with the model register file:
- dbg_reg_we pulses for exactly one cycle;
- read result is 0x1234_5678.
REQ-025 Halted, READ_MEM at addr 0x100 with dbg_mem_ready delayed 3 cycles and rdata=0xCAFEF00D:
- dbg_mem_re is held for 4 cycles;
- core_busy stays 1 throughout;
- result is 0xCAFEF00D.
REQ-026 Not halted, READ_REG:
- result 0xFFFF_FFFF, debug_error=1, dbg_reg_addr access has no effect;
- a following NOP clears debug_error.
REQ-027 Halted, STEP with instr_retired pulsed 5 cycles after EXEC:
- core_halt=0 for exactly those cycles, then 1;
- result=1.
REQ-028 rst=0 asserted during MEM_WAIT:
- dbg_mem_re=0 and core_busy=0 next cycle;
- a fresh NOP sequence then completes normally.
